// File: rtl/watch_mode_ctrl_if.sv
// Button/tick inputs and display/datapath control outputs of the watch mode controller.
// Latency: none (wiring only); no backpressure, every signal is a level or single-cycle pulse.
interface watch_mode_ctrl_if;
    logic       i_btn_mode;
    logic       i_btn_set;
    logic       i_btn_inc;
    logic       i_btn_dec;
    logic       i_btn_light;
    logic       i_tick_1hz;
    logic       i_tick_2hz;
    logic [1:0] o_mode;
    logic [1:0] o_edit_field;
    logic       o_adj_inc;
    logic       o_adj_dec;
    logic       o_time_run;
    logic       o_alarm_en;
    logic       o_sw_run;
    logic       o_sw_clear;
    logic       o_blank_h;
    logic       o_blank_m;
    logic       o_blank_s;
    logic       o_colon;
    logic       o_light;

    modport master (
        output i_btn_mode, i_btn_set, i_btn_inc, i_btn_dec, i_btn_light,
        output i_tick_1hz, i_tick_2hz,
        input  o_mode, o_edit_field, o_adj_inc, o_adj_dec, o_time_run,
        input  o_alarm_en, o_sw_run, o_sw_clear, o_blank_h, o_blank_m,
        input  o_blank_s, o_colon, o_light
    );

    modport slave (
        input  i_btn_mode, i_btn_set, i_btn_inc, i_btn_dec, i_btn_light,
        input  i_tick_1hz, i_tick_2hz,
        output o_mode, o_edit_field, o_adj_inc, o_adj_dec, o_time_run,
        output o_alarm_en, o_sw_run, o_sw_clear, o_blank_h, o_blank_m,
        output o_blank_s, o_colon, o_light
    );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Watch control FSM: view/edit/stopwatch sequencing, adjust strobes, blink, colon, backlight.
// Latency: every output registered, one clock after the causing button/tick; no backpressure.
module watch_mode_ctrl #(
    parameter int LIGHT_SECS   = 3,
    parameter int EDIT_TIMEOUT = 30
) (
    input  logic               clk,
    input  logic               rst,
    watch_mode_ctrl_if.slave   io_bus
);
    localparam int TO_W = $clog2(EDIT_TIMEOUT + 1);
    localparam int LT_W = $clog2(LIGHT_SECS + 1);

    localparam logic [2:0] S_T_VIEW   = 3'd0;
    localparam logic [2:0] S_T_EDIT_H = 3'd1;
    localparam logic [2:0] S_T_EDIT_M = 3'd2;
    localparam logic [2:0] S_T_EDIT_S = 3'd3;
    localparam logic [2:0] S_A_VIEW   = 3'd4;
    localparam logic [2:0] S_A_EDIT_H = 3'd5;
    localparam logic [2:0] S_A_EDIT_M = 3'd6;
    localparam logic [2:0] S_SW       = 3'd7;

    logic [2:0]      r_state;
    logic [1:0]      r_mode;
    logic [1:0]      r_field;
    logic [TO_W-1:0] r_to_cnt;
    logic [LT_W-1:0] r_lt_cnt;
    logic            r_blink;
    logic            r_adj_inc;
    logic            r_adj_dec;
    logic            r_time_run;
    logic            r_alarm_en;
    logic            r_sw_run;
    logic            r_sw_clear;
    logic            r_blank_h;
    logic            r_blank_m;
    logic            r_blank_s;
    logic            r_colon;
    logic            r_light;

    logic            w_p_mode;
    logic            w_p_set;
    logic            w_p_inc;
    logic            w_p_dec;
    logic            w_any_btn;
    logic            w_cur_edit;
    logic            w_timeout;
    logic [2:0]      w_state_nxt;
    logic [1:0]      w_mode_nxt;
    logic [1:0]      w_field_nxt;
    logic            w_blink_nxt;
    logic            w_colon_nxt;
    logic [TO_W-1:0] w_to_nxt;
    logic [LT_W-1:0] w_lt_nxt;

    // Only the highest-priority button acts; btn_light stays out of the FSM entirely.
    assign w_p_mode   = io_bus.i_btn_mode;
    assign w_p_set    = io_bus.i_btn_set & ~io_bus.i_btn_mode;
    assign w_p_inc    = io_bus.i_btn_inc & ~io_bus.i_btn_mode & ~io_bus.i_btn_set;
    assign w_p_dec    = io_bus.i_btn_dec & ~io_bus.i_btn_mode & ~io_bus.i_btn_set
                        & ~io_bus.i_btn_inc;
    assign w_any_btn  = io_bus.i_btn_mode | io_bus.i_btn_set | io_bus.i_btn_inc
                        | io_bus.i_btn_dec;
    assign w_cur_edit = (r_field != 2'd0);
    assign w_timeout  = w_cur_edit && !w_any_btn && io_bus.i_tick_1hz
                        && (r_to_cnt == TO_W'(EDIT_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_T_VIEW: begin
                if (w_p_mode)     w_state_nxt = S_A_VIEW;
                else if (w_p_set) w_state_nxt = S_T_EDIT_H;
            end
            S_T_EDIT_H: begin
                if (w_p_mode || w_timeout) w_state_nxt = S_T_VIEW;
                else if (w_p_set)          w_state_nxt = S_T_EDIT_M;
            end
            S_T_EDIT_M: begin
                if (w_p_mode || w_timeout) w_state_nxt = S_T_VIEW;
                else if (w_p_set)          w_state_nxt = S_T_EDIT_S;
            end
            S_T_EDIT_S: begin
                if (w_p_mode || w_timeout || w_p_set) w_state_nxt = S_T_VIEW;
            end
            S_A_VIEW: begin
                if (w_p_mode)     w_state_nxt = S_SW;
                else if (w_p_set) w_state_nxt = S_A_EDIT_H;
            end
            S_A_EDIT_H: begin
                if (w_p_mode || w_timeout) w_state_nxt = S_A_VIEW;
                else if (w_p_set)          w_state_nxt = S_A_EDIT_M;
            end
            S_A_EDIT_M: begin
                if (w_p_mode || w_timeout || w_p_set) w_state_nxt = S_A_VIEW;
            end
            S_SW: begin
                if (w_p_mode) w_state_nxt = S_T_VIEW;
            end
            default: w_state_nxt = S_T_VIEW;
        endcase
    end

    always_comb begin
        w_mode_nxt  = 2'd0;
        w_field_nxt = 2'd0;
        case (w_state_nxt)
            S_T_EDIT_H: w_field_nxt = 2'd1;
            S_T_EDIT_M: w_field_nxt = 2'd2;
            S_T_EDIT_S: w_field_nxt = 2'd3;
            S_A_VIEW:   w_mode_nxt  = 2'd1;
            S_A_EDIT_H: begin w_mode_nxt = 2'd1; w_field_nxt = 2'd1; end
            S_A_EDIT_M: begin w_mode_nxt = 2'd1; w_field_nxt = 2'd2; end
            S_SW:       w_mode_nxt  = 2'd2;
            default:    w_mode_nxt  = 2'd0;
        endcase
    end

    always_comb begin
        w_to_nxt = r_to_cnt;
        if (w_any_btn || (w_field_nxt == 2'd0)) w_to_nxt = '0;
        else if (io_bus.i_tick_1hz)             w_to_nxt = r_to_cnt + TO_W'(1);

        w_blink_nxt = r_blink;
        if (w_any_btn)              w_blink_nxt = 1'b0;
        else if (io_bus.i_tick_2hz) w_blink_nxt = ~r_blink;

        // Colon only blinks while staying in T_VIEW; any arrival there shows it solid first.
        w_colon_nxt = 1'b1;
        if (w_state_nxt == S_T_VIEW && r_state == S_T_VIEW && io_bus.i_tick_2hz)
            w_colon_nxt = ~r_colon;
        else if (w_state_nxt == S_T_VIEW && r_state == S_T_VIEW)
            w_colon_nxt = r_colon;

        w_lt_nxt = r_lt_cnt;
        if (io_bus.i_btn_light)                              w_lt_nxt = LT_W'(LIGHT_SECS);
        else if (io_bus.i_tick_1hz && (r_lt_cnt != '0))      w_lt_nxt = r_lt_cnt - LT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_T_VIEW;
            r_mode     <= 2'd0;
            r_field    <= 2'd0;
            r_to_cnt   <= '0;
            r_lt_cnt   <= '0;
            r_blink    <= 1'b0;
            r_adj_inc  <= 1'b0;
            r_adj_dec  <= 1'b0;
            r_time_run <= 1'b1;
            r_alarm_en <= 1'b0;
            r_sw_run   <= 1'b0;
            r_sw_clear <= 1'b0;
            r_blank_h  <= 1'b0;
            r_blank_m  <= 1'b0;
            r_blank_s  <= 1'b0;
            r_colon    <= 1'b1;
            r_light    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_field    <= w_field_nxt;
            r_to_cnt   <= w_to_nxt;
            r_lt_cnt   <= w_lt_nxt;
            r_blink    <= w_blink_nxt;
            r_adj_inc  <= w_cur_edit & w_p_inc;
            r_adj_dec  <= w_cur_edit & w_p_dec;
            r_time_run <= !((w_mode_nxt == 2'd0) && (w_field_nxt != 2'd0));
            if (r_state == S_A_VIEW && w_p_inc) r_alarm_en <= ~r_alarm_en;
            if (r_state == S_SW && w_p_set)     r_sw_run   <= ~r_sw_run;
            r_sw_clear <= (r_state == S_SW) && w_p_inc && !r_sw_run;
            r_blank_h  <= (w_field_nxt == 2'd1) && w_blink_nxt;
            r_blank_m  <= (w_field_nxt == 2'd2) && w_blink_nxt;
            r_blank_s  <= (w_field_nxt == 2'd3) && w_blink_nxt;
            r_colon    <= w_colon_nxt;
            r_light    <= (w_lt_nxt != '0);
        end
    end

    assign io_bus.o_mode       = r_mode;
    assign io_bus.o_edit_field = r_field;
    assign io_bus.o_adj_inc    = r_adj_inc;
    assign io_bus.o_adj_dec    = r_adj_dec;
    assign io_bus.o_time_run   = r_time_run;
    assign io_bus.o_alarm_en   = r_alarm_en;
    assign io_bus.o_sw_run     = r_sw_run;
    assign io_bus.o_sw_clear   = r_sw_clear;
    assign io_bus.o_blank_h    = r_blank_h;
    assign io_bus.o_blank_m    = r_blank_m;
    assign io_bus.o_blank_s    = r_blank_s;
    assign io_bus.o_colon      = r_colon;
    assign io_bus.o_light      = r_light;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl: each step drives one cycle of inputs, then checks outputs.
module tb_watch_mode_ctrl;
    localparam logic [6:0] B_NONE  = 7'h00;
    localparam logic [6:0] B_MODE  = 7'h40;
    localparam logic [6:0] B_SET   = 7'h20;
    localparam logic [6:0] B_INC   = 7'h10;
    localparam logic [6:0] B_DEC   = 7'h08;
    localparam logic [6:0] B_LIGHT = 7'h04;
    localparam logic [6:0] B_T1    = 7'h02;
    localparam logic [6:0] B_T2    = 7'h01;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    watch_mode_ctrl_if bus ();

    watch_mode_ctrl #(.LIGHT_SECS(3), .EDIT_TIMEOUT(30)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic [6:0] v);
        {bus.i_btn_mode, bus.i_btn_set, bus.i_btn_inc, bus.i_btn_dec,
         bus.i_btn_light, bus.i_tick_1hz, bus.i_tick_2hz} = v;
    endtask

    // Present v for one rising edge, then sample #1 after that edge.
    task automatic drive(input logic [6:0] v);
        set_inputs(v);
        @(posedge clk);
        #1;
        set_inputs(B_NONE);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        set_inputs(B_NONE);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode",     8'(bus.o_mode), 8'd0);
        chk("rst_field",    8'(bus.o_edit_field), 8'd0);
        chk("rst_time_run", 8'(bus.o_time_run), 8'd1);
        chk("rst_colon",    8'(bus.o_colon), 8'd1);
        chk("rst_misc",     {bus.o_adj_inc, bus.o_adj_dec, bus.o_alarm_en, bus.o_sw_run,
                             bus.o_sw_clear, bus.o_blank_h, bus.o_light, bus.o_blank_m}, 8'd0);
        rst = 1'b0;
        drive(B_NONE);

        // Time edit: set, inc, inc, dec
        drive(B_SET);
        chk("edit_field_h", 8'(bus.o_edit_field), 8'd1);
        chk("edit_time_run", 8'(bus.o_time_run), 8'd0);
        chk("no_adj_on_set", 8'(bus.o_adj_inc), 8'd0);
        drive(B_INC);
        chk("adj_inc_1", 8'(bus.o_adj_inc), 8'd1);
        chk("adj_inc_field", 8'(bus.o_edit_field), 8'd1);
        drive(B_NONE);
        chk("adj_inc_1_drop", 8'(bus.o_adj_inc), 8'd0);
        drive(B_INC);
        chk("adj_inc_2", 8'(bus.o_adj_inc), 8'd1);
        drive(B_DEC);
        chk("adj_dec_1", {bus.o_adj_inc, bus.o_adj_dec}, 8'b01);
        drive(B_NONE);
        chk("adj_dec_drop", {bus.o_adj_inc, bus.o_adj_dec}, 8'b00);
        drive(B_T2);
        chk("blink_h_on", 8'(bus.o_blank_h), 8'd1);
        drive(B_INC | B_T2);
        chk("blink_forced_off", 8'(bus.o_blank_h), 8'd0);
        drive(B_SET);
        chk("edit_field_m", 8'(bus.o_edit_field), 8'd2);
        drive(B_SET);
        chk("edit_field_s", 8'(bus.o_edit_field), 8'd3);
        drive(B_SET);
        chk("edit_exit", {bus.o_mode, bus.o_edit_field, 3'b0, bus.o_time_run}, 8'h01);

        // Async reset in T_EDIT_M
        drive(B_SET);
        drive(B_SET);
        chk("pre_rst_field", 8'(bus.o_edit_field), 8'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_field", 8'(bus.o_edit_field), 8'd0);
        chk("async_rst_time_run", 8'(bus.o_time_run), 8'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(B_NONE);
        chk("post_rst_state", {bus.o_mode, bus.o_edit_field, 3'b0, bus.o_time_run}, 8'h01);

        // Colon blinks in T_VIEW
        drive(B_T2);
        chk("colon_off", 8'(bus.o_colon), 8'd0);
        drive(B_T2);
        chk("colon_on", 8'(bus.o_colon), 8'd1);

        // Priority mode over set, then alarm and stopwatch
        drive(B_MODE | B_SET);
        chk("prio_mode", {bus.o_mode, bus.o_edit_field}, 8'b0100);
        drive(B_INC);
        chk("alarm_on", 8'(bus.o_alarm_en), 8'd1);
        drive(B_INC);
        chk("alarm_off", 8'(bus.o_alarm_en), 8'd0);
        drive(B_MODE);
        chk("sw_mode", 8'(bus.o_mode), 8'd2);
        drive(B_SET);
        chk("sw_run_on", 8'(bus.o_sw_run), 8'd1);
        drive(B_INC);
        chk("sw_no_clear_running", 8'(bus.o_sw_clear), 8'd0);
        drive(B_SET);
        chk("sw_run_off", 8'(bus.o_sw_run), 8'd0);
        drive(B_INC);
        chk("sw_clear_pulse", 8'(bus.o_sw_clear), 8'd1);
        drive(B_NONE);
        chk("sw_clear_drop", 8'(bus.o_sw_clear), 8'd0);
        drive(B_MODE);
        chk("sw_back_tview", {bus.o_mode, bus.o_edit_field, 3'b0, bus.o_sw_run}, 8'h00);

        // Edit timeout
        drive(B_SET);
        for (int i = 0; i < 29; i++) drive(B_T1);
        chk("to_29_still_edit", 8'(bus.o_edit_field), 8'd1);
        drive(B_T1);
        chk("to_30_exit", {bus.o_mode, bus.o_edit_field}, 8'd0);
        drive(B_SET);
        for (int i = 0; i < 28; i++) drive(B_T1);
        drive(B_INC | B_T1);
        for (int i = 0; i < 29; i++) drive(B_T1);
        chk("to_restart_29", 8'(bus.o_edit_field), 8'd1);
        drive(B_T1);
        chk("to_restart_exit", 8'(bus.o_edit_field), 8'd0);

        // Backlight
        drive(B_LIGHT);
        chk("light_on", 8'(bus.o_light), 8'd1);
        drive(B_T1);
        chk("light_t1", 8'(bus.o_light), 8'd1);
        drive(B_T1);
        chk("light_t2", 8'(bus.o_light), 8'd1);
        drive(B_T1);
        chk("light_t3_off", 8'(bus.o_light), 8'd0);
        drive(B_LIGHT);
        drive(B_T1);
        drive(B_T1);
        drive(B_LIGHT | B_T1);
        chk("light_reload", 8'(bus.o_light), 8'd1);
        drive(B_T1);
        chk("light_reload_t1", 8'(bus.o_light), 8'd1);
        drive(B_T1);
        drive(B_T1);
        chk("light_reload_off", 8'(bus.o_light), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
